// File: rtl/dcache_coherence_agent_if.sv
// dcache_coherence_agent_if: CPU-side request/response and bus-side coherence signals of one agent.
interface dcache_coherence_agent_if;
    logic        dmemREN, dmemWEN, dhit;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        dREN, dWEN, cctrans, ccwrite, dwait, ccwait, ccinv;
    logic [31:0] daddr, dstore, dload, ccsnoopaddr;

    modport master (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
    );
    modport slave (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
    );
endinterface

// File: rtl/dcache_coherence_agent.sv
// dcache_coherence_agent: direct-mapped write-back MSI cache agent with snoop service.
// Define DCACHE_STATS_EN to add hitcount/misscount ports.
module dcache_coherence_agent #(
    parameter int SETS = 8
) (
    input  logic CLK,
    input  logic nRST,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hitcount,
    output logic [31:0] misscount,
`endif
    dcache_coherence_agent_if.master cif
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 29 - IW;

    typedef enum logic [2:0] {IDLE, WB1, WB2, RD1, RD2, UPG} state_t;
    state_t state, next;

    logic [SETS-1:0] valid, dirty;
    logic [TW-1:0]   tags [SETS];
    logic [31:0]     w0 [SETS], w1 [SETS];
    logic [31:0]     fill0;
    logic            snp_m;

    logic [IW-1:0] idx, sidx;
    logic [TW-1:0] tg, stg;
    logic [31:0]   word, sword;
    logic          hit, shit, snp_wr, req, acc, unused;

    assign idx    = cif.dmemaddr[IW+2:3];
    assign tg     = cif.dmemaddr[31:IW+3];
    assign sidx   = cif.ccsnoopaddr[IW+2:3];
    assign stg    = cif.ccsnoopaddr[31:IW+3];
    assign word   = cif.dmemaddr[2] ? w1[idx] : w0[idx];
    assign sword  = cif.ccsnoopaddr[2] ? w1[sidx] : w0[sidx];
    assign hit    = valid[idx] && tags[idx] == tg;
    assign shit   = valid[sidx] && tags[sidx] == stg;
    // snp_m keeps the Modified response alive after an invalidating snoop has already dropped the frame
    assign snp_wr = (shit && dirty[sidx]) || snp_m;
    assign req    = cif.dmemREN || cif.dmemWEN;
    assign acc    = !cif.ccwait && !cif.dwait;
    assign unused = ^{cif.dmemaddr[1:0], cif.ccsnoopaddr[1:0]};

    always_comb begin
        next         = state;
        cif.dhit     = 1'b0;
        cif.dmemload = '0;
        cif.dREN     = 1'b0;
        cif.dWEN     = 1'b0;
        cif.cctrans  = 1'b0;
        cif.ccwrite  = 1'b0;
        cif.daddr    = '0;
        cif.dstore   = '0;
        if (cif.ccwait) begin
            cif.ccwrite = snp_wr;
            cif.daddr   = snp_wr ? cif.ccsnoopaddr : '0;
            cif.dstore  = snp_wr ? sword : '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit && (cif.dmemREN || dirty[idx])) begin
                        cif.dhit     = 1'b1;
                        cif.dmemload = word;
                    end else if (req)
                        next = hit ? UPG : (valid[idx] && dirty[idx]) ? WB1 : RD1;
                end
                WB1, WB2: begin
                    cif.dWEN    = 1'b1;
                    cif.cctrans = 1'b1;
                    cif.daddr   = {tags[idx], idx, state == WB2, 2'b00};
                    cif.dstore  = state == WB2 ? w1[idx] : w0[idx];
                    if (!cif.dwait) next = state == WB1 ? WB2 : RD1;
                end
                RD1, RD2: begin
                    cif.dREN    = 1'b1;
                    cif.cctrans = 1'b1;
                    cif.ccwrite = cif.dmemWEN;
                    cif.daddr   = {tg, idx, state == RD2, 2'b00};
                    if (!cif.dwait) next = state == RD1 ? RD2 : IDLE;
                end
                UPG: begin
                    cif.cctrans = 1'b1;
                    cif.ccwrite = 1'b1;
                    // losing the frame mid-upgrade turns the request into a write fill
                    if (!hit) next = RD1;
                    else if (!cif.dwait) next = IDLE;
                end
                default: next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            fill0 <= '0;
            snp_m <= 1'b0;
        end else begin
            state <= next;
            snp_m <= cif.ccwait && snp_wr;
            if (cif.ccwait) begin
                if (shit && cif.ccinv) valid[sidx] <= 1'b0;
                if (shit) dirty[sidx] <= 1'b0;
            end else begin
                if (state == RD1 && !cif.dwait) fill0 <= cif.dload;
                if (state == RD2 && !cif.dwait) begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= cif.dmemWEN;
                end
                if (state == UPG && hit && !cif.dwait) dirty[idx] <= 1'b1;
                if (state == WB2 && !cif.dwait) dirty[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (acc && state == RD2) begin
            tags[idx] <= tg;
            w0[idx]   <= fill0;
            w1[idx]   <= cif.dload;
        end
        if (cif.dhit && cif.dmemWEN) begin
            if (cif.dmemaddr[2]) w1[idx] <= cif.dmemstore;
            else w0[idx] <= cif.dmemstore;
        end
    end

`ifdef DCACHE_STATS_EN
    logic pend;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitcount  <= '0;
            misscount <= '0;
            pend      <= 1'b0;
        end else begin
            if (cif.dhit) pend <= 1'b0;
            else if (state == IDLE && next != IDLE) pend <= 1'b1;
            if (cif.dhit && !pend) hitcount <= hitcount + 32'd1;
            if (state == IDLE && next != IDLE) misscount <= misscount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_coherence_agent.sv
// tb_dcache_coherence_agent: directed scoreboard bench for the MSI cache agent.
module tb_dcache_coherence_agent;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    dcache_coherence_agent_if cif();
    dcache_coherence_agent #(.SETS(8)) dut (.CLK(CLK), .nRST(nRST), .cif(cif));

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        cw;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] cpu_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic bx(input int k, input logic [31:0] a, input logic [31:0] d, input logic cw);
        bus_q.push_back('{k, a, d, cw});
    endtask

    task automatic check_idle_outs(input string name);
        check({name, "_flags"}, {cif.dhit, cif.dREN, cif.dWEN, cif.cctrans, cif.ccwrite}, 0);
        check({name, "_daddr"}, cif.daddr, 0);
        check({name, "_dstore"}, cif.dstore, 0);
        check({name, "_dmemload"}, cif.dmemload, 0);
    endtask

    task automatic cpu_op(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp,
                          input int cyc, input int snp_at, input int rst_at);
        bus_t b;
        logic [31:0] e;
        int n;
        bit done;
        @(negedge CLK);
        cif.dwait = 1'b1;
        cif.dmemREN = ren;
        cif.dmemWEN = wen;
        cif.dmemaddr = addr;
        cif.dmemstore = data;
        cpu_q.push_back(exp);
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            #1;
            if (n == rst_at) begin
                nRST = 1'b0;
                #1;
                check_idle_outs("rst_mid");
                cpu_q.delete();
                bus_q.delete();
                done = 1;
            end else if (n == snp_at) begin
                cif.ccwait = 1'b1;
                cif.ccinv = 1'b1;
                cif.ccsnoopaddr = addr;
                #1;
                check("upg_snoop_gate", {cif.dhit, cif.dREN, cif.dWEN, cif.cctrans}, 0);
                check("upg_snoop_ccwrite", cif.ccwrite, 0);
            end else if (cif.dhit) begin
                e = cpu_q.pop_front();
                if (ren) check("load_data", cif.dmemload, e);
                check("latency", n, cyc);
                done = 1;
            end else if (cif.cctrans) begin
                if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    b = bus_q.pop_front();
                    check("bus_kind", cif.dREN ? 0 : cif.dWEN ? 1 : 2, b.kind);
                    check("bus_ccwrite", cif.ccwrite, b.cw);
                    if (b.kind != 2) check("bus_addr", cif.daddr, b.addr);
                    if (b.kind == 1) check("bus_dstore", cif.dstore, b.data);
                    cif.dload = b.data;
                    cif.dwait = 1'b0;
                end
            end
            @(negedge CLK);
            cif.dwait = 1'b1;
            cif.ccwait = 1'b0;
            cif.ccinv = 1'b0;
            n++;
        end
        if (!done) check("timeout", n, cyc);
        if (rst_at >= 0) nRST = 1'b1;
        cif.dmemREN = 1'b0;
        cif.dmemWEN = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] addr, input logic inv, input logic cw,
                         input logic [31:0] st, input int len);
        @(negedge CLK);
        cif.ccwait = 1'b1;
        cif.ccinv = inv;
        cif.ccsnoopaddr = addr;
        cif.dmemREN = 1'b1;
        cif.dmemaddr = addr;
        for (int i = 0; i < len; i++) begin
            #1;
            check("snp_ccwrite", cif.ccwrite, cw);
            check("snp_gate", {cif.dhit, cif.dREN, cif.dWEN, cif.cctrans}, 0);
            if (cw) begin
                check("snp_daddr", cif.daddr, addr);
                check("snp_dstore", cif.dstore, st);
            end
            cif.dwait = 1'b0;
            @(negedge CLK);
            cif.dwait = 1'b1;
        end
        cif.ccwait = 1'b0;
        cif.ccinv = 1'b0;
        cif.dmemREN = 1'b0;
    endtask

    initial begin
        cif.dmemREN = 0; cif.dmemWEN = 0; cif.dmemaddr = 0; cif.dmemstore = 0;
        cif.dwait = 1; cif.dload = 0; cif.ccwait = 0; cif.ccinv = 0; cif.ccsnoopaddr = 0;
        #1;
        check_idle_outs("reset");
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        bx(0, 32'h40, 32'hAAAA, 0); bx(0, 32'h44, 32'hBBBB, 0);
        cpu_op(1, 0, 32'h40, 0, 32'hAAAA, 3, -1, -1);
        bx(2, 0, 0, 1);
        cpu_op(0, 1, 32'h40, 32'h1234, 0, 2, -1, -1);
        cpu_op(1, 0, 32'h40, 0, 32'h1234, 0, -1, -1);
        bx(1, 32'h40, 32'h1234, 0); bx(1, 32'h44, 32'hBBBB, 0);
        bx(0, 32'h140, 32'hC0C0, 0); bx(0, 32'h144, 32'hC1C1, 0);
        cpu_op(1, 0, 32'h140, 0, 32'hC0C0, 5, -1, -1);
        cpu_op(1, 0, 32'h144, 0, 32'hC1C1, 0, -1, -1);
        bx(0, 32'h40, 32'h1111, 0); bx(0, 32'h44, 32'hBBBB, 0);
        cpu_op(1, 0, 32'h40, 0, 32'h1111, 3, -1, -1);
        bx(2, 0, 0, 1);
        cpu_op(0, 1, 32'h40, 32'h3333, 0, 2, -1, -1);

        snoop(32'h44, 0, 1, 32'hBBBB, 1);
        snoop(32'h240, 0, 0, 0, 1);
        snoop(32'h40, 0, 0, 0, 1);
        bx(2, 0, 0, 1);
        cpu_op(0, 1, 32'h44, 32'h4444, 0, 2, -1, -1);
        snoop(32'h40, 0, 1, 32'h3333, 1);

        bx(2, 0, 0, 1); bx(0, 32'h40, 32'h6666, 1); bx(0, 32'h44, 32'h7777, 1);
        cpu_op(0, 1, 32'h40, 32'h5555, 0, 5, 1, -1);
        cpu_op(1, 0, 32'h40, 0, 32'h5555, 0, -1, -1);
        cpu_op(1, 0, 32'h44, 0, 32'h7777, 0, -1, -1);

        snoop(32'h44, 1, 1, 32'h7777, 2);
        bx(0, 32'h40, 32'h8888, 0); bx(0, 32'h44, 32'h9999, 0);
        cpu_op(1, 0, 32'h40, 0, 32'h8888, 3, -1, -1);

        bx(0, 32'h140, 32'hDEAD, 0); bx(0, 32'h144, 32'hBEEF, 0);
        cpu_op(1, 0, 32'h140, 0, 0, 0, -1, 2);
        bx(0, 32'h40, 32'hAB01, 0); bx(0, 32'h44, 32'hAB02, 0);
        cpu_op(1, 0, 32'h40, 0, 32'hAB01, 3, -1, -1);

        check("bus_q_drained", bus_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
